// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter in front of a single memory controller port
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_address,
    output logic        if_ready,
    output logic [31:0] if_data,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_rw,
    input  logic [31:0] ls_address,
    input  logic [31:0] ls_write_data,
    input  logic [1:0]  ls_size,
    output logic        ls_ready,
    output logic [31:0] ls_data,
    output logic        ls_err,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_read_data,
    input  logic        mem_data_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic        last_grant;   // 0 = fetch won last, 1 = load/store won last
    logic        grant_ls;     // owner of the transaction in flight
    logic [7:0]  count;

    logic        any_req;
    logic        pick_ls;
    logic [31:0] pick_address;
    logic        timeout_hit;

    logic        load;
    logic        load_ls;
    logic [31:0] load_data;
    logic        load_err;

    // Winner selection: a lone requester wins, a tie goes to whoever lost last time
    always_comb begin
        any_req      = if_req | ls_req;
        pick_ls      = ls_req & (~if_req | ~last_grant);
        pick_address = pick_ls ? ls_address : if_address;
        timeout_hit  = ({1'b0, count} + 9'd1) >= {1'b0, TIMEOUT};
    end

    // Response capture: decides when and what the requester-facing data/err registers latch
    always_comb begin
        load      = 1'b0;
        load_ls   = grant_ls;
        load_data = 32'd0;
        load_err  = 1'b0;
        case (state)
            IDLE: begin
                // Addresses with bit 31 set are IO space: fail without touching memory
                if (any_req && pick_address[31]) begin
                    load     = 1'b1;
                    load_ls  = pick_ls;
                    load_err = 1'b1;
                end
            end
            WAIT: begin
                if (mem_data_valid) begin
                    load      = 1'b1;
                    load_data = mem_rw ? 32'd0 : mem_read_data;
                end else if (timeout_hit) begin
                    load     = 1'b1;
                    load_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Arbitration state machine and the registered memory command
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b0;
            grant_ls       <= 1'b0;
            count          <= 8'd0;
            mem_rw         <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            mem_size       <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_ls    <= pick_ls;
                        mem_address <= pick_address;
                        if (pick_ls) begin
                            mem_rw         <= ls_rw;
                            mem_write_data <= ls_write_data;
                            mem_size       <= ls_size;
                        end else begin
                            mem_rw         <= 1'b0;
                            mem_write_data <= 32'd0;
                            mem_size       <= 2'd2;
                        end
                        state <= pick_address[31] ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    count <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (load) begin
                        state <= RESP;
                    end else if (count != 8'hFF) begin
                        count <= count + 8'd1;
                    end
                end
                default: begin
                    last_grant <= grant_ls;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Requester-facing data/err hold their value until the next response for that side
    always_ff @(posedge clk) begin
        if (reset) begin
            if_data <= 32'd0;
            if_err  <= 1'b0;
            ls_data <= 32'd0;
            ls_err  <= 1'b0;
        end else if (load) begin
            if (load_ls) begin
                ls_data <= load_data;
                ls_err  <= load_err;
            end else begin
                if_data <= load_data;
                if_err  <= load_err;
            end
        end
    end

    assign mem_rw_req = (state == ISSUE);
    assign if_ready   = (state == RESP) & ~grant_ls;
    assign ls_ready   = (state == RESP) &  grant_ls;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_address = 32'd0;
    logic        ls_req = 1'b0;
    logic        ls_rw = 1'b0;
    logic [31:0] ls_address = 32'd0;
    logic [31:0] ls_write_data = 32'd0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] mem_read_data = 32'd0;
    logic        mem_data_valid = 1'b0;
    logic        if_ready, if_err, ls_ready, ls_err;
    logic [31:0] if_data, ls_data;
    logic        mem_rw_req, mem_rw;
    logic [31:0] mem_address, mem_write_data;
    logic [1:0]  mem_size;

    logic        if_req_t = 1'b0;
    logic        mv_t = 1'b0;
    logic [31:0] mrd_t = 32'd0;
    logic        if_ready_t, if_err_t, ls_ready_t, ls_err_t;
    logic [31:0] if_data_t, ls_data_t;
    logic        mem_rw_req_t, mem_rw_t;
    logic [31:0] mem_address_t, mem_write_data_t;
    logic [1:0]  mem_size_t;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_address(if_address),
        .if_ready(if_ready), .if_data(if_data), .if_err(if_err),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_address(ls_address),
        .ls_write_data(ls_write_data), .ls_size(ls_size),
        .ls_ready(ls_ready), .ls_data(ls_data), .ls_err(ls_err),
        .mem_rw_req(mem_rw_req), .mem_rw(mem_rw), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_size(mem_size),
        .mem_read_data(mem_read_data), .mem_data_valid(mem_data_valid)
    );

    mem_arbiter #(.TIMEOUT(8'd4)) dut_t (
        .clk(clk), .reset(reset),
        .if_req(if_req_t), .if_address(if_address),
        .if_ready(if_ready_t), .if_data(if_data_t), .if_err(if_err_t),
        .ls_req(1'b0), .ls_rw(1'b0), .ls_address(32'd0),
        .ls_write_data(32'd0), .ls_size(2'd0),
        .ls_ready(ls_ready_t), .ls_data(ls_data_t), .ls_err(ls_err_t),
        .mem_rw_req(mem_rw_req_t), .mem_rw(mem_rw_t), .mem_address(mem_address_t),
        .mem_write_data(mem_write_data_t), .mem_size(mem_size_t),
        .mem_read_data(mrd_t), .mem_data_valid(mv_t)
    );

    typedef struct {
        logic        is_ls;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        logic        err;
        int          at_cyc;   // -1: must be the cycle after mem_data_valid
        logic        chk;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[8];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_delay = 5;
    int cd = -1;
    int last_valid = -100;
    int issues = 0;
    logic [31:0] pend = 32'd0;
    logic        chk_mem = 1'b0;
    logic        em_rw = 1'b0;
    logic [1:0]  em_size = 2'd0;
    logic [31:0] em_addr = 32'd0;
    logic [31:0] em_wdata = 32'd0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory controller model: answers each issue mem_delay cycles later with mem_f(address)
    always @(negedge clk) begin
        mem_data_valid = 1'b0;
        if (reset) begin
            cd = -1;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_data_valid = 1'b1;
                    mem_read_data  = pend;
                    last_valid     = cyc;
                    cd             = -1;
                end
            end
            if (mem_rw_req) begin
                issues++;
                if (last_valid >= 0) check("issue_gap_ge3", (cyc - last_valid) >= 3, 1);
                if (chk_mem) begin
                    check("issue_rw", mem_rw, em_rw);
                    check("issue_size", mem_size, em_size);
                    check("issue_addr", mem_address, em_addr);
                    if (em_rw) check("issue_wdata", mem_write_data, em_wdata);
                end
                cd   = mem_delay;
                pend = mem_f(mem_address);
            end
        end
    end

    // Scoreboard: every ready pulse pops one expected response
    always @(negedge clk) begin
        if (!reset && (if_ready || ls_ready)) begin
            check("single_ready", if_ready & ls_ready, 0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got if=%0b ls=%0b expected none", if_ready, ls_ready);
            end else begin
                e = sb.pop_front();
                check("ready_port", ls_ready, e.is_ls);
                check("resp_data", e.is_ls ? ls_data : if_data, e.data);
                check("resp_err", e.is_ls ? ls_err : if_err, e.err);
                if (e.at_cyc >= 0) check("resp_cycle", cyc, e.at_cyc);
                else               check("resp_after_valid", cyc, last_valid + 1);
                if (e.chk) begin
                    check("stable_addr", mem_address, e.addr);
                    check("stable_size", mem_size, e.size);
                    check("stable_rw", mem_rw, e.rw);
                    if (e.rw) check("stable_wdata", mem_write_data, e.wdata);
                end
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; if_req_t = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t x;
        int   base;
        logic got;
        logic io;
        @(negedge clk);
        io = v.addr[31];
        base = issues;
        em_rw    = v.is_ls ? v.rw : 1'b0;
        em_size  = v.is_ls ? v.size : 2'd2;
        em_addr  = v.addr;
        em_wdata = v.wdata;
        chk_mem  = 1'b1;
        if (v.is_ls) begin
            ls_rw = v.rw; ls_size = v.size; ls_address = v.addr; ls_write_data = v.wdata; ls_req = 1'b1;
        end else begin
            if_address = v.addr; if_req = 1'b1;
        end
        x.is_ls = v.is_ls; x.data = v.exp_data; x.err = v.exp_err;
        x.at_cyc = io ? cyc + 1 : -1;
        x.chk = !io; x.rw = em_rw; x.size = em_size; x.addr = em_addr; x.wdata = em_wdata;
        sb.push_back(x);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (v.is_ls ? ls_ready : if_ready) got = 1'b1;
        end
        check("vec_ready_seen", got, 1);
        if_req = 1'b0; ls_req = 1'b0;
        check("vec_issue_count", issues - base, io ? 0 : 1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'd0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'd0, mem_f(32'h400), 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'd0, 32'd0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_0203, 32'h0000_00AB, 32'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 32'h7FFF_FFFC, 32'd0, mem_f(32'h7FFFFFFC), 1'b0};
        vecs[5] = '{1'b0, 1'b0, 2'd2, 32'h8000_0000, 32'd0, 32'd0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 2'd1, 32'h0000_0402, 32'h0000_BEEF, 32'd0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'h1234_5678, 32'd0, 1'b0};

        pulse_reset();
        check("reset_outputs",
              {mem_rw_req, mem_rw, mem_address, mem_write_data, mem_size,
               if_ready, if_data, if_err, ls_ready, ls_data, ls_err}, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Tie after reset: ls first, then strict alternation while both stay high
        begin
            int   n;
            logic [3:0] order;
            exp_t x;
            pulse_reset();
            chk_mem = 1'b0;
            @(negedge clk);
            if_address = 32'h0000_1000; ls_address = 32'h0000_2000;
            ls_rw = 1'b0; ls_size = 2'd2;
            if_req = 1'b1; ls_req = 1'b1;
            for (int k = 0; k < 4; k++) begin
                x.is_ls = (k % 2 == 0);
                x.data = x.is_ls ? mem_f(32'h2000) : mem_f(32'h1000);
                x.err = 1'b0; x.at_cyc = -1; x.chk = 1'b0;
                x.rw = 1'b0; x.size = 2'd2; x.addr = 32'd0; x.wdata = 32'd0;
                sb.push_back(x);
            end
            n = 0; order = 4'd0;
            for (int i = 0; i < 200 && n < 4; i++) begin
                @(negedge clk);
                if (if_ready || ls_ready) begin
                    order[n] = ls_ready;
                    n++;
                end
            end
            if_req = 1'b0; ls_req = 1'b0;
            check("tie_count", n, 4);
            check("tie_order", order, 4'b0101);
        end

        // Timeout with TIMEOUT=4, then a stray mem_data_valid in IDLE
        begin
            int   ic, rc;
            logic quiet;
            pulse_reset();
            @(negedge clk);
            if_address = 32'h0000_0300; if_req_t = 1'b1;
            ic = -1; rc = -1;
            for (int i = 0; i < 20 && ic < 0; i++) begin
                @(negedge clk);
                if (mem_rw_req_t) ic = cyc;
            end
            for (int i = 0; i < 40 && rc < 0; i++) begin
                @(negedge clk);
                if (if_ready_t) rc = cyc;
            end
            if_req_t = 1'b0;
            check("to_issue_seen", ic >= 0, 1);
            check("to_latency", rc - ic, 5);
            check("to_err", if_err_t, 1);
            check("to_data", if_data_t, 0);
            @(negedge clk);
            mv_t = 1'b1; mrd_t = 32'hCAFE_F00D;
            @(negedge clk);
            mv_t = 1'b0;
            quiet = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (if_ready_t || mem_rw_req_t) quiet = 1'b0;
            end
            check("late_valid_ignored", quiet, 1);
            check("late_valid_data", {if_err_t, if_data_t}, {1'b1, 32'd0});
        end

        // Reset mid-WAIT aborts silently; the held request is granted again
        begin
            int   base;
            logic seen;
            exp_t x;
            pulse_reset();
            mem_delay = 20;
            chk_mem = 1'b1; em_rw = 1'b0; em_size = 2'd2; em_addr = 32'h0000_0500;
            @(negedge clk);
            if_address = 32'h0000_0500; if_req = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (mem_rw_req) seen = 1'b1;
            end
            check("abort_issue_seen", seen, 1);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("abort_outputs",
                  {mem_rw_req, mem_rw, mem_address, mem_write_data, mem_size,
                   if_ready, if_data, if_err, ls_ready, ls_data, ls_err}, 0);
            reset = 1'b0;
            base = issues;
            x.is_ls = 1'b0; x.data = mem_f(32'h500); x.err = 1'b0; x.at_cyc = -1;
            x.chk = 1'b1; x.rw = 1'b0; x.size = 2'd2; x.addr = 32'h0000_0500; x.wdata = 32'd0;
            sb.push_back(x);
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (if_ready) seen = 1'b1;
            end
            if_req = 1'b0;
            check("regrant_ready", seen, 1);
            check("regrant_issues", issues - base, 1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
